// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: shifts one datasize-bit frame out MSB-first on mosi while
// capturing the simultaneous miso reply, then pulses done with the result.
module spi_master_tx #(
    parameter int unsigned datasize = 128,
    parameter int unsigned CLKDIV   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [datasize-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic [datasize-1:0] rx_data,
    output logic                sclk,
    output logic                cs,
    output logic                mosi,
    input  logic                miso
);

    localparam int unsigned BW = $clog2(datasize);
    localparam int unsigned DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    // MSB goes straight from data_in to mosi, so only the remaining bits are kept
    logic [datasize-2:0]   tx_q, tx_d;
    logic [datasize-1:0]   rx_q, rx_d;
    logic [datasize-1:0]   rx_data_q, rx_data_d;
    logic                  sclk_q, sclk_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  phase_end;

    assign phase_end = (div_q == DW'(CLKDIV - 1));

    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        bit_d     = bit_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rx_data_q;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (state_q != IDLE && !phase_end) begin
            div_d = div_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_d    = data_in[datasize-2:0];
                    mosi_d  = data_in[datasize-1];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP, LOW: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[datasize-2:0], miso};
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (bit_q == BW'(datasize - 1)) begin
                        state_d = HOLD;
                    end else begin
                        mosi_d  = tx_q[datasize-2];
                        tx_d    = tx_q << 1;
                        bit_d   = bit_q + 1'b1;
                        state_d = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_end) begin
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            rx_data_q <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            rx_data_q <= rx_data_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: default 128-bit/CLKDIV=2 instance with
// loopback or a mode-0 slave model, plus two 8-bit instances (CLKDIV=1 and 3).
module tb_spi_master_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A: datasize=128, CLKDIV=2
    logic         start_a, busy_a, done_a, sclk_a, cs_a, mosi_a, miso_a;
    logic [127:0] data_a, rx_a;
    logic         loop_a;
    logic         slv_miso = 1'b0;
    assign miso_a = loop_a ? mosi_a : slv_miso;

    // instance B: datasize=8, CLKDIV=1 ; instance C: datasize=8, CLKDIV=3
    logic       start_b, busy_b, done_b, sclk_b, cs_b, mosi_b, miso_b;
    logic [7:0] data_b, rx_b;
    logic       start_c, busy_c, done_c, sclk_c, cs_c, mosi_c, miso_c;
    logic [7:0] data_c, rx_c;
    assign miso_b = mosi_b;
    assign miso_c = mosi_c;

    spi_master_tx dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_a), .busy(busy_a),
        .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_tx #(.datasize(8), .CLKDIV(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_b), .busy(busy_b),
        .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b), .miso(miso_b)
    );

    spi_master_tx #(.datasize(8), .CLKDIV(3)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .data_in(data_c), .busy(busy_c),
        .done(done_c), .rx_data(rx_c), .sclk(sclk_c), .cs(cs_c), .mosi(mosi_c), .miso(miso_c)
    );

    // Monitors and mode-0 slave for instance A
    logic [127:0] reply = 128'h3243f6a8885a308d313198a2e0370734;
    logic [127:0] srx   = '0;
    int           sidx  = 127;
    logic         sclk_a_p = 1'b0, cs_a_p = 1'b1;
    int unsigned  rise_a = 0, done_cnt_a = 0, csfall_a = 0;

    always @(negedge clk) begin
        sclk_a_p <= sclk_a;
        cs_a_p   <= cs_a;
        if (sclk_a === 1'b1 && sclk_a_p === 1'b0) begin
            rise_a <= rise_a + 1;
            srx    <= {srx[126:0], mosi_a};
        end
        if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
        if (cs_a === 1'b0 && cs_a_p === 1'b1) begin
            csfall_a <= csfall_a + 1;
            slv_miso <= reply[127];
            sidx     <= 126;
        end else if (sclk_a === 1'b0 && sclk_a_p === 1'b1 && cs_a === 1'b0) begin
            slv_miso <= reply[sidx];
            if (sidx > 0) sidx <= sidx - 1;
        end
    end

    // Phase-length and mosi-stability monitor for instance C
    logic        sclk_c_p = 1'b0, mosi_c_p = 1'b0, fell_c = 1'b0;
    int unsigned run_c = 0, hmin_c = 1000, hmax_c = 0, lmin_c = 1000, lmax_c = 0, viol_c = 0;

    always @(negedge clk) begin
        sclk_c_p <= sclk_c;
        mosi_c_p <= mosi_c;
        if (cs_c === 1'b1) fell_c <= 1'b0;
        else if (sclk_c_p === 1'b1 && sclk_c === 1'b0) fell_c <= 1'b1;
        if (sclk_c !== sclk_c_p) begin
            run_c <= 1;
            if (sclk_c === 1'b0) begin
                if (run_c < hmin_c) hmin_c <= run_c;
                if (run_c > hmax_c) hmax_c <= run_c;
            end else if (fell_c) begin
                if (run_c < lmin_c) lmin_c <= run_c;
                if (run_c > lmax_c) lmax_c <= run_c;
            end
        end else begin
            run_c <= run_c + 1;
        end
        if (mosi_c !== mosi_c_p && sclk_c === 1'b1) viol_c <= viol_c + 1;
    end

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns the cycle at which done is seen, or 0 if the budget runs out.
    task automatic wait_done(input int which, input int unsigned limit, output int unsigned at);
        at = 0;
        for (int unsigned i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((which == 0 && done_a === 1'b1) || (which == 1 && done_b === 1'b1) ||
                (which == 2 && done_c === 1'b1)) begin
                at = cyc;
                return;
            end
        end
    endtask

    // Accept a frame on instance A; returns the first cycle with cs low.
    task automatic start_a_frame(input logic [127:0] d, output int unsigned t1);
        @(negedge clk);
        data_a  = d;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t1      = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    logic [127:0] kx = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    int unsigned  t1, at, at2, s0, s1, s2;

    initial begin
        rst = 1'b1; loop_a = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_cs",   cs_a,   1'b1);
        check("rst_sclk", sclk_a, 1'b0);
        check("rst_mosi", mosi_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_rx",   rx_a,   '0);

        // Loopback frame
        s0 = rise_a;
        start_a_frame(kx, t1);
        check("acc_cs",   cs_a,   1'b0);
        check("acc_mosi", mosi_a, kx[127]);
        check("acc_busy", busy_a, 1'b1);
        wait_done(0, 1000, at);
        check("lb_latency", at - t1, 514);
        check("lb_rx",      rx_a, kx);
        check("lb_rises",   rise_a - s0, 128);
        @(negedge clk);
        check("lb_busy_after", busy_a, 1'b0);
        check("lb_cs_after",   cs_a,   1'b1);
        check("lb_done_clr",   done_a, 1'b0);

        // Slave model frame
        loop_a = 1'b0;
        start_a_frame(kx, t1);
        wait_done(0, 1000, at);
        check("slv_latency", at - t1, 514);
        check("slv_rx",      rx_a, reply);
        check("slv_got",     srx,  kx);

        // start pulses during a frame are ignored
        loop_a = 1'b1;
        repeat (3) @(negedge clk);
        s1 = done_cnt_a; s2 = csfall_a;
        start_a_frame(kx, t1);
        while (cyc < t1 + 49) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        while (cyc < t1 + 299) @(negedge clk);
        start_a = 1'b1; @(negedge clk); start_a = 1'b0;
        wait_done(0, 1000, at);
        check("ign_latency", at - t1, 514);
        check("ign_rx",      rx_a, kx);
        repeat (10) @(negedge clk);
        check("ign_dones",  done_cnt_a - s1, 1);
        check("ign_cslows", csfall_a - s2,   1);
        check("ign_cs",     cs_a, 1'b1);

        // Reset mid-frame aborts
        start_a_frame(reply, t1);
        while (cyc < t1 + 199) @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("abort_cs",   cs_a,   1'b1);
        check("abort_sclk", sclk_a, 1'b0);
        check("abort_mosi", mosi_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_rx",   rx_a,   '0);
        s1 = done_cnt_a;
        repeat (600) @(negedge clk);
        check("abort_nodone", done_cnt_a - s1, 0);
        start_a_frame(reply, t1);
        wait_done(0, 1000, at);
        check("post_latency", at - t1, 514);
        check("post_rx",      rx_a, reply);

        // Back-to-back frames, CLKDIV=1, datasize=8
        @(negedge clk);
        data_b  = 8'hA5;
        start_b = 1'b1;
        @(negedge clk);
        t1 = cyc;
        check("b2b_acc_cs",   cs_b,   1'b0);
        check("b2b_acc_mosi", mosi_b, 1'b1);
        data_b = 8'h3C;
        wait_done(1, 100, at);
        check("b2b_latency", at - t1, 17);
        check("b2b_rx0",     rx_b, 8'hA5);
        check("b2b_cs_hi",   cs_b, 1'b1);
        @(negedge clk);
        check("b2b_cs_relow", cs_b, 1'b0);
        wait_done(1, 100, at2);
        start_b = 1'b0;
        check("b2b_period", at2 - at, 18);
        check("b2b_rx1",    rx_b, 8'h3C);
        @(negedge clk);
        check("b2b_stop_cs",   cs_b,   1'b1);
        check("b2b_stop_busy", busy_b, 1'b0);

        // Phase timing, CLKDIV=3, datasize=8
        @(negedge clk);
        data_c  = 8'h96;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        t1      = cyc;
        wait_done(2, 200, at);
        check("div3_latency", at - t1, 51);
        check("div3_rx",      rx_c,   8'h96);
        check("div3_hmin",    hmin_c, 3);
        check("div3_hmax",    hmax_c, 3);
        check("div3_lmin",    lmin_c, 3);
        check("div3_lmax",    lmax_c, 3);
        check("div3_mosi",    viol_c, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
